control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 115 +++++++++++
 tb/tb_control_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle processor control FSM (fetch/decode/execute/memory/writeback/halt)
// Optional WAIT_STATE_EN: FETCH and MEMORY hold until mem_ready is sampled high.
module control_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] instrucao,
  input  logic       mem_ready,
  output logic       PCwrite,
  output logic       IRwrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [2:0] ALUop,
  output logic [1:0] OPcontrole,
  output logic       halted,
  output logic [2:0] estado
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'b000,
    S_FETCH     = 3'b001,
    S_DECODE    = 3'b010,
    S_EXECUTE   = 3'b011,
    S_MEMORY    = 3'b100,
    S_WRITEBACK = 3'b101,
    S_HALT      = 3'b110,
    S_INVALID   = 3'b111
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_LI    = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_t     state;
  state_t     state_next;
  logic [2:0] opcode;
  logic       advance;

`ifdef WAIT_STATE_EN
  assign advance = mem_ready;
  logic [4:0] unused_operand;
  assign unused_operand = instrucao[4:0];
`else
  assign advance = 1'b1;
  logic [5:0] unused_inputs;
  assign unused_inputs = {mem_ready, instrucao[4:0]};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      opcode <= 3'b000;
    end else begin
      state <= state_next;
      if (state == S_FETCH && advance)
        opcode <= instrucao[7:5];
    end
  end

  always_comb begin
    state_next = state;
    PCwrite    = 1'b0;
    IRwrite    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    ALUop      = 3'b000;
    OPcontrole = 2'b00;
    halted     = 1'b0;
    case (state)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        IRwrite = 1'b1;
        // PC increments only on the cycle the instruction is actually taken
        PCwrite = advance;
        if (advance)
          state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMORY;
          OP_LI:             state_next = S_WRITEBACK;
          OP_HALT:           state_next = S_HALT;
          default:           state_next = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        ALUop      = opcode;
        state_next = S_WRITEBACK;
      end
      S_MEMORY: begin
        MemRead  = (opcode == OP_LOAD);
        MemWrite = (opcode == OP_STORE);
        if (advance)
          state_next = (opcode == OP_LOAD) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        RegWrite = 1'b1;
        case (opcode)
          OP_LOAD: OPcontrole = 2'b01;
          OP_LI:   OPcontrole = 2'b10;
          default: OPcontrole = 2'b00;
        endcase
        state_next = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  assign estado = state;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit against a per-instruction cycle table model
module tb_control_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] instrucao = 8'h00;
  logic       mem_ready = 1'b1;
  logic       PCwrite, IRwrite, MemRead, MemWrite, RegWrite, halted;
  logic [2:0] ALUop, estado;
  logic [1:0] OPcontrole;

  int total = 0;
  int bad   = 0;

  logic [14:0] exp_seq [0:4];
  int          exp_len;

  control_unit dut (
    .clock(clock), .reset(reset), .instrucao(instrucao), .mem_ready(mem_ready),
    .PCwrite(PCwrite), .IRwrite(IRwrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUop(ALUop), .OPcontrole(OPcontrole), .halted(halted),
    .estado(estado)
  );

  always #5 clock = ~clock;

  function automatic logic [14:0] obs();
    return {estado, PCwrite, IRwrite, MemRead, MemWrite, RegWrite, ALUop, OPcontrole, halted};
  endfunction

  function automatic logic [14:0] mk(input int st, input bit pc, input bit ir, input bit mr,
                                     input bit mw, input bit rw, input int alu, input int opc,
                                     input bit h);
    return {3'(st), pc, ir, mr, mw, rw, 3'(alu), 2'(opc), h};
  endfunction

  // Expected per-cycle outputs of one instruction, starting with its FETCH cycle
  task automatic model(input logic [2:0] op);
    exp_seq[0] = mk(1, 1, 1, 1, 0, 0, 0, 0, 0);
    exp_seq[1] = mk(2, 0, 0, 0, 0, 0, 0, 0, 0);
    if (op <= 3'd3) begin
      exp_seq[2] = mk(3, 0, 0, 0, 0, 0, int'(op), 0, 0);
      exp_seq[3] = mk(5, 0, 0, 0, 0, 1, 0, 0, 0);
      exp_len = 4;
    end else if (op == 3'd4) begin
      exp_seq[2] = mk(4, 0, 0, 1, 0, 0, 0, 0, 0);
      exp_seq[3] = mk(5, 0, 0, 0, 0, 1, 0, 1, 0);
      exp_len = 4;
    end else if (op == 3'd5) begin
      exp_seq[2] = mk(4, 0, 0, 0, 1, 0, 0, 0, 0);
      exp_len = 3;
    end else if (op == 3'd6) begin
      exp_seq[2] = mk(5, 0, 0, 0, 0, 1, 0, 2, 0);
      exp_len = 3;
    end else begin
      exp_seq[2] = mk(6, 0, 0, 0, 0, 0, 0, 0, 1);
      exp_len = 3;
    end
  endtask

  task automatic start_after_reset();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 15'd0) begin bad++; $display("FAIL reset_async got=%h exp=%h", obs(), 15'd0); end
    repeat (3) begin
      @(negedge clock);
      total++;
      if (obs() !== 15'd0) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs(), 15'd0); end
    end
    reset = 1'b0;
    #1;
    total++;
    if (obs() !== 15'd0) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs(), 15'd0); end
    @(posedge clock);
    @(negedge clock);
    total++;
    if (estado !== 3'b001) begin bad++; $display("FAIL reset_to_fetch got=%0d exp=1", estado); end
  endtask

  task automatic test_alu();
    instrucao = 8'b000_00101;
    model(3'b000);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (obs() !== exp_seq[i]) begin bad++; $display("FAIL alu cyc%0d got=%h exp=%h", i, obs(), exp_seq[i]); end
      @(negedge clock);
    end
    total++;
    if (estado !== 3'b001) begin bad++; $display("FAIL alu_len got=%0d exp=1", estado); end
  endtask

  task automatic test_load();
    instrucao = 8'b100_00011;
    model(3'b100);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (obs() !== exp_seq[i]) begin bad++; $display("FAIL load cyc%0d got=%h exp=%h", i, obs(), exp_seq[i]); end
      @(negedge clock);
    end
    total++;
    if (estado !== 3'b001) begin bad++; $display("FAIL load_len got=%0d exp=1", estado); end
  endtask

  task automatic test_store_li();
    logic [7:0] prog [0:1];
    prog[0] = 8'b101_00001;
    prog[1] = 8'b110_01010;
    for (int k = 0; k < 2; k++) begin
      instrucao = prog[k];
      model(prog[k][7:5]);
      for (int i = 0; i < exp_len; i++) begin
        total++;
        if (obs() !== exp_seq[i]) begin bad++; $display("FAIL store_li k%0d cyc%0d got=%h exp=%h", k, i, obs(), exp_seq[i]); end
        @(negedge clock);
      end
      total++;
      if (estado !== 3'b001) begin bad++; $display("FAIL store_li_len k%0d got=%0d exp=1", k, estado); end
    end
  endtask

  // Back-to-back random instructions; instrucao is scrambled after FETCH to show the opcode is held
  task automatic test_random();
    logic [2:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 6));
      instrucao = {op, 5'($urandom)};
      model(op);
      for (int i = 0; i < exp_len; i++) begin
        if (i == 1) instrucao = 8'($urandom);
`ifdef WAIT_STATE_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'($urandom);
`endif
        #1;
        total++;
        if (obs() !== exp_seq[i]) begin bad++; $display("FAIL random n%0d op%0d cyc%0d got=%h exp=%h", n, op, i, obs(), exp_seq[i]); end
        @(negedge clock);
      end
      total++;
      if (estado !== 3'b001) begin bad++; $display("FAIL random_len n%0d got=%0d exp=1", n, estado); end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    instrucao = 8'b101_00001;
    model(3'b101);
    for (int i = 0; i < exp_len; i++) begin
      total++;
      if (obs() !== exp_seq[i]) begin bad++; $display("FAIL midrst cyc%0d got=%h exp=%h", i, obs(), exp_seq[i]); end
      if (i < exp_len - 1) @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 15'd0) begin bad++; $display("FAIL midrst_async got=%h exp=%h", obs(), 15'd0); end
    start_after_reset();
    total++;
    if (estado !== 3'b001) begin bad++; $display("FAIL midrst_restart got=%0d exp=1", estado); end
  endtask

  task automatic test_halt();
    instrucao = 8'b111_00000;
    model(3'b111);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs() !== exp_seq[i]) begin bad++; $display("FAIL halt cyc%0d got=%h exp=%h", i, obs(), exp_seq[i]); end
      @(negedge clock);
    end
    for (int i = 0; i < 20; i++) begin
      instrucao = 8'($urandom);
      total++;
      if (obs() !== exp_seq[2]) begin bad++; $display("FAIL halt_hold cyc%0d got=%h exp=%h", i, obs(), exp_seq[2]); end
      @(negedge clock);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (obs() !== 15'd0) begin bad++; $display("FAIL halt_reset got=%h exp=%h", obs(), 15'd0); end
    start_after_reset();
  endtask

`ifdef WAIT_STATE_EN
  task automatic test_wait_state();
    logic [2:0] seq [0:3];
    seq[0] = 3'd2; seq[1] = 3'd3; seq[2] = 3'd5; seq[3] = 3'd1;
    instrucao = 8'b001_00111;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({estado, PCwrite, MemRead, IRwrite} !== {3'd1, 1'b0, 1'b1, 1'b1})
        begin bad++; $display("FAIL wait_hold cyc%0d got=%h exp=%h", i, {estado, PCwrite, MemRead, IRwrite}, {3'd1, 3'b011}); end
      @(negedge clock);
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if (PCwrite !== 1'b1) begin bad++; $display("FAIL wait_pcwrite got=%b exp=1", PCwrite); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if (estado !== seq[i]) begin bad++; $display("FAIL wait_seq cyc%0d got=%0d exp=%0d", i, estado, seq[i]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store_li();
    test_random();
    test_mid_reset();
`ifdef WAIT_STATE_EN
    test_wait_state();
`endif
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
